// File: rtl/dmc_dma_unit_pkg.sv
// Shared APU definitions: DMC DMA sequencer states and the fixed sample-space address bit.
package dmc_dma_unit_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    DUMMY,
    ALIGN,
    GET,
    WAIT
  } dma_state_e;

  localparam logic DMC_ADDR_MSB = 1'b1;

endpackage

// File: rtl/dmc_dma_unit.sv
// DMC sample-fetch responder: stalls the 6502 with NES DMA timing (halt, dummy, align, get),
// reads one byte from {1'b1, dmc_addr} and hands it back to the APU with a one-cycle strobe.
module dmc_dma_unit
  import dmc_dma_unit_pkg::*;
#(
  parameter int MEM_LAT       = 1,
  parameter int PENDING_DEPTH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_clk_en,
  input  logic        apu_put,
  input  logic        dmc_re,
  input  logic [14:0] dmc_addr,
  input  logic        cpu_rw,
  input  logic [7:0]  mem_rdata,
  output logic        cpu_rdy,
  output logic        bus_grant,
  output logic [15:0] mem_addr,
  output logic        mem_re,
  output logic [7:0]  dmc_read_data,
  output logic        dmc_data_valid,
  output logic        busy
);

  localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);
  localparam logic       PEND_EN  = (PENDING_DEPTH > 0);

  dma_state_e  state, state_n;
  logic [15:0] addr_q;
  logic [15:0] pend_addr;
  logic [15:0] mem_addr_q;
  logic        pend_valid;
  logic        chain;
  logic [1:0]  lat_cnt;
  logic [7:0]  data_q;
  logic        valid_q;

  logic req;
  logic wait_last;
  logic take_pend;
  logic take_new;
  logic go_idle;
  logic accept;

  // The slot counts as occupied until the request it held has been served (chain),
  // so only one request beyond the active one is ever accepted per busy period.
  assign req       = dmc_re & cpu_clk_en;
  assign wait_last = (state == WAIT) && (lat_cnt == LAT_LAST);
  assign take_pend = wait_last && pend_valid;
  assign take_new  = wait_last && !pend_valid && req && !chain && PEND_EN;
  assign go_idle   = wait_last && !take_pend && !take_new;
  assign accept    = req && PEND_EN && (state != IDLE) && !pend_valid && !chain && !wait_last;

  always_comb begin
    state_n   = state;
    cpu_rdy   = 1'b0;
    bus_grant = 1'b0;
    mem_re    = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        cpu_rdy = 1'b1;
        busy    = 1'b0;
        if (req) state_n = HALT;
      end
      // The 6502 ignores RDY during writes, so wait for a read cycle before stealing.
      HALT:  if (cpu_rw) state_n = DUMMY;
      DUMMY: state_n = apu_put ? GET : ALIGN;
      ALIGN: state_n = GET;
      GET: begin
        bus_grant = 1'b1;
        mem_re    = cpu_clk_en;
        state_n   = WAIT;
      end
      WAIT: begin
        bus_grant = 1'b1;
        cpu_rdy   = go_idle;
        if (wait_last) state_n = go_idle ? IDLE : HALT;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      pend_addr  <= '0;
      pend_valid <= 1'b0;
      chain      <= 1'b0;
      lat_cnt    <= '0;
      mem_addr_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
    end else if (cpu_clk_en) begin
      state   <= state_n;
      valid_q <= 1'b0;
      lat_cnt <= (state == WAIT && !wait_last) ? lat_cnt + 2'd1 : 2'd0;
      if (state == IDLE && req) addr_q <= {DMC_ADDR_MSB, dmc_addr};
      if (accept) begin
        pend_valid <= 1'b1;
        pend_addr  <= {DMC_ADDR_MSB, dmc_addr};
      end
      if (take_pend) begin
        addr_q     <= pend_addr;
        pend_valid <= 1'b0;
        chain      <= 1'b1;
      end
      if (take_new) begin
        addr_q <= {DMC_ADDR_MSB, dmc_addr};
        chain  <= 1'b1;
      end
      if (go_idle) chain <= 1'b0;
      if (state_n == GET) mem_addr_q <= addr_q;
      if (wait_last) begin
        data_q  <= mem_rdata;
        valid_q <= 1'b1;
      end
    end
  end

  assign mem_addr       = mem_addr_q;
  assign dmc_read_data  = data_q;
  assign dmc_data_valid = valid_q & cpu_clk_en;

endmodule

// File: tb/tb_dmc_dma_unit.sv
// Directed bench for dmc_dma_unit: scripted enabled-cycle stimulus, per-cycle output capture,
// hand-computed expectations for stall length, fetch address/data and pending behaviour.
module tb_dmc_dma_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_clk_en;
  logic        apu_put;
  logic        dmc_re;
  logic [14:0] dmc_addr;
  logic        cpu_rw;
  logic [7:0]  mem_rdata;

  logic        cpu_rdy_a, bus_grant_a, mem_re_a, dmc_data_valid_a, busy_a;
  logic [15:0] mem_addr_a;
  logic [7:0]  dmc_read_data_a;
  logic        cpu_rdy_b, bus_grant_b, mem_re_b, dmc_data_valid_b, busy_b;
  logic [15:0] mem_addr_b;
  logic [7:0]  dmc_read_data_b;

  dmc_dma_unit #(.MEM_LAT(1)) dut (
    .clk(clk), .rst(rst), .cpu_clk_en(cpu_clk_en), .apu_put(apu_put),
    .dmc_re(dmc_re), .dmc_addr(dmc_addr), .cpu_rw(cpu_rw), .mem_rdata(mem_rdata),
    .cpu_rdy(cpu_rdy_a), .bus_grant(bus_grant_a), .mem_addr(mem_addr_a), .mem_re(mem_re_a),
    .dmc_read_data(dmc_read_data_a), .dmc_data_valid(dmc_data_valid_a), .busy(busy_a)
  );

  dmc_dma_unit #(.MEM_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .cpu_clk_en(cpu_clk_en), .apu_put(apu_put),
    .dmc_re(dmc_re), .dmc_addr(dmc_addr), .cpu_rw(cpu_rw), .mem_rdata(mem_rdata),
    .cpu_rdy(cpu_rdy_b), .bus_grant(bus_grant_b), .mem_addr(mem_addr_b), .mem_re(mem_re_b),
    .dmc_read_data(dmc_read_data_b), .dmc_data_valid(dmc_data_valid_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  // sel picks which instance the recorder observes: 0 = MEM_LAT 1, 1 = MEM_LAT 2
  logic        sel = 1'b0;
  logic        o_rdy, o_grant, o_re, o_val, o_busy;
  logic [15:0] o_addr;
  logic [7:0]  o_data;
  assign o_rdy   = sel ? cpu_rdy_b        : cpu_rdy_a;
  assign o_grant = sel ? bus_grant_b      : bus_grant_a;
  assign o_re    = sel ? mem_re_b         : mem_re_a;
  assign o_val   = sel ? dmc_data_valid_b : dmc_data_valid_a;
  assign o_busy  = sel ? busy_b           : busy_a;
  assign o_addr  = sel ? mem_addr_b       : mem_addr_a;
  assign o_data  = sel ? dmc_read_data_b  : dmc_read_data_a;

  int checks = 0;
  int errors = 0;
  int en_period = 1;
  int en_cnt = 0;
  int put_phase = 0;
  bit rd_ramp = 1'b0;
  logic [7:0] rd_base = 8'h00;
  int dis_pulse = 0;

  logic        re_v [32];
  logic [14:0] addr_v [32];
  logic        rw_v [32];
  logic        rst_v [32];

  logic        rec_rdy [32];
  logic        rec_grant [32];
  logic        rec_re [32];
  logic        rec_val [32];
  logic        rec_busy [32];
  logic        rec_put [32];
  logic [15:0] rec_addr [32];
  logic [7:0]  rec_data [32];

  int          rdy_low, re_cnt, val_cnt, rises, re_cyc0, re_cyc1, val_cyc0;
  logic [15:0] re_addr0, re_addr1;
  logic        re_put0;
  logic [7:0]  val_data0, val_data1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    en_cnt++;
    cpu_clk_en = (en_period <= 1) || (en_cnt % en_period == 0);
  endtask

  task automatic doReset();
    en_period  = 1;
    en_cnt     = 0;
    cpu_clk_en = 1'b1;
    rst        = 1'b1;
    dmc_re     = 1'b0;
    dmc_addr   = '0;
    cpu_rw     = 1'b1;
    apu_put    = 1'b0;
    mem_rdata  = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic clearScript();
    for (int i = 0; i < 32; i++) begin
      re_v[i]   = 1'b0;
      addr_v[i] = '0;
      rw_v[i]   = 1'b1;
      rst_v[i]  = 1'b0;
    end
    put_phase = 0;
    rd_ramp   = 1'b0;
    rd_base   = 8'h00;
  endtask

  // Runs n enabled cycles of the script; apu_put alternates, mem_rdata optionally ramps per enabled cycle.
  task automatic applyStimulus(input int n);
    dis_pulse = 0;
    for (int e = 0; e < n; e++) begin
      int guard;
      guard = 0;
      while (!cpu_clk_en && guard < 64) begin
        #1;
        if (o_val || o_re) dis_pulse++;
        tick();
        guard++;
      end
      if (!cpu_clk_en) begin
        checkOutput("enable_timeout", 32'd0, 32'd1);
        break;
      end
      dmc_re    = re_v[e];
      dmc_addr  = addr_v[e];
      cpu_rw    = rw_v[e];
      apu_put   = (((e + put_phase) & 1) == 0);
      rst       = rst_v[e];
      mem_rdata = rd_ramp ? rd_base + 8'(e) : rd_base;
      #1;
      rec_rdy[e]   = o_rdy;
      rec_grant[e] = o_grant;
      rec_re[e]    = o_re;
      rec_val[e]   = o_val;
      rec_busy[e]  = o_busy;
      rec_put[e]   = apu_put;
      rec_addr[e]  = o_addr;
      rec_data[e]  = o_data;
      tick();
      dmc_re = 1'b0;
      rst    = 1'b0;
    end
  endtask

  task automatic analyze(input int n);
    rdy_low = 0; re_cnt = 0; val_cnt = 0; rises = 0;
    re_cyc0 = -1; re_cyc1 = -1; val_cyc0 = -1;
    re_addr0 = '0; re_addr1 = '0; re_put0 = 1'b1;
    val_data0 = '0; val_data1 = '0;
    for (int e = 0; e < n; e++) begin
      if (!rec_rdy[e]) rdy_low++;
      if (e > 0 && rec_rdy[e] && !rec_rdy[e-1]) rises++;
      if (rec_re[e]) begin
        if (re_cnt == 0) begin
          re_addr0 = rec_addr[e]; re_cyc0 = e; re_put0 = rec_put[e];
        end else if (re_cnt == 1) begin
          re_addr1 = rec_addr[e]; re_cyc1 = e;
        end
        re_cnt++;
      end
      if (rec_val[e]) begin
        if (val_cnt == 0) begin
          val_data0 = rec_data[e]; val_cyc0 = e;
        end else if (val_cnt == 1) begin
          val_data1 = rec_data[e];
        end
        val_cnt++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    doReset();
    #1;
    checkOutput("rst_cpu_rdy", cpu_rdy_a, 1'b1);
    checkOutput("rst_bus_grant", bus_grant_a, 1'b0);
    checkOutput("rst_mem_addr", mem_addr_a, 16'h0000);
    checkOutput("rst_mem_re", mem_re_a, 1'b0);
    checkOutput("rst_read_data", dmc_read_data_a, 8'h00);
    checkOutput("rst_data_valid", dmc_data_valid_a, 1'b0);
    checkOutput("rst_busy", busy_a, 1'b0);

    // Basic fetch, DUMMY lands on a put cycle: halt, dummy, get
    doReset(); clearScript();
    re_v[0] = 1'b1; addr_v[0] = 15'h4000; rd_base = 8'hA5;
    applyStimulus(8); analyze(8);
    checkOutput("t1_rdy_low", rdy_low, 3);
    checkOutput("t1_re_cnt", re_cnt, 1);
    checkOutput("t1_re_addr", re_addr0, 16'hC000);
    checkOutput("t1_re_cycle", re_cyc0, 3);
    checkOutput("t1_re_on_get", re_put0, 1'b0);
    checkOutput("t1_grant_in_get", rec_grant[3], 1'b1);
    checkOutput("t1_val_cnt", val_cnt, 1);
    checkOutput("t1_val_data", val_data0, 8'hA5);
    checkOutput("t1_val_cycle", val_cyc0, 5);
    checkOutput("t1_data_held", rec_data[7], 8'hA5);
    checkOutput("t1_idle_busy", rec_busy[7], 1'b0);

    // DUMMY lands on a get cycle, so ALIGN is inserted
    doReset(); clearScript();
    re_v[0] = 1'b1; addr_v[0] = 15'h4000; rd_base = 8'hA5; put_phase = 1;
    applyStimulus(8); analyze(8);
    checkOutput("t2_rdy_low", rdy_low, 4);
    checkOutput("t2_re_cycle", re_cyc0, 4);
    checkOutput("t2_re_on_get", re_put0, 1'b0);
    checkOutput("t2_re_addr", re_addr0, 16'hC000);
    checkOutput("t2_val_data", val_data0, 8'hA5);

    // CPU finishing writes holds HALT for two extra cycles
    doReset(); clearScript();
    re_v[0] = 1'b1; addr_v[0] = 15'h1234; rd_base = 8'h5A;
    rw_v[1] = 1'b0; rw_v[2] = 1'b0;
    applyStimulus(10); analyze(10);
    checkOutput("t3_rdy_low", rdy_low, 5);
    checkOutput("t3_re_cnt", re_cnt, 1);
    checkOutput("t3_re_cycle", re_cyc0, 5);
    checkOutput("t3_re_addr", re_addr0, 16'h9234);
    checkOutput("t3_val_data", val_data0, 8'h5A);
    checkOutput("t3_val_cycle", val_cyc0, 7);

    // Back-to-back: second request in WAIT chains, third in the second's HALT is dropped
    doReset(); clearScript();
    re_v[0] = 1'b1; addr_v[0] = 15'h0000;
    re_v[4] = 1'b1; addr_v[4] = 15'h0001;
    re_v[5] = 1'b1; addr_v[5] = 15'h0002;
    rd_ramp = 1'b1; rd_base = 8'h10;
    applyStimulus(14); analyze(14);
    checkOutput("t4_re_cnt", re_cnt, 2);
    checkOutput("t4_re_addr0", re_addr0, 16'h8000);
    checkOutput("t4_re_addr1", re_addr1, 16'h8001);
    checkOutput("t4_re_cycle1", re_cyc1, 7);
    checkOutput("t4_rdy_low", rdy_low, 7);
    checkOutput("t4_rdy_rises", rises, 1);
    checkOutput("t4_val_cnt", val_cnt, 2);
    checkOutput("t4_val_data0", val_data0, 8'h14);
    checkOutput("t4_val_data1", val_data1, 8'h18);

    // Reset in GET aborts; a later request completes normally
    doReset(); clearScript();
    re_v[0] = 1'b1; addr_v[0] = 15'h4000; rst_v[3] = 1'b1;
    re_v[6] = 1'b1; addr_v[6] = 15'h7FFF; rd_base = 8'h3C;
    applyStimulus(14); analyze(14);
    checkOutput("t5_rdy_after_rst", rec_rdy[4], 1'b1);
    checkOutput("t5_grant_after_rst", rec_grant[4], 1'b0);
    checkOutput("t5_busy_after_rst", rec_busy[4], 1'b0);
    checkOutput("t5_addr_after_rst", rec_addr[4], 16'h0000);
    checkOutput("t5_re_cnt", re_cnt, 2);
    checkOutput("t5_re_addr1", re_addr1, 16'hFFFF);
    checkOutput("t5_val_cnt", val_cnt, 1);
    checkOutput("t5_val_cycle", val_cyc0, 11);
    checkOutput("t5_val_data", val_data0, 8'h3C);

    // MEM_LAT=2 with a 1-in-12 CPU enable
    doReset(); clearScript();
    sel = 1'b1;
    re_v[0] = 1'b1; addr_v[0] = 15'h4000; rd_ramp = 1'b1; rd_base = 8'h40;
    en_period = 12; en_cnt = 0;
    applyStimulus(9); analyze(9);
    checkOutput("t6_rdy_low", rdy_low, 4);
    checkOutput("t6_re_cnt", re_cnt, 1);
    checkOutput("t6_re_cycle", re_cyc0, 3);
    checkOutput("t6_re_addr", re_addr0, 16'hC000);
    checkOutput("t6_grant_wait0", rec_grant[4], 1'b1);
    checkOutput("t6_grant_wait1", rec_grant[5], 1'b1);
    checkOutput("t6_val_cnt", val_cnt, 1);
    checkOutput("t6_val_cycle", val_cyc0, 6);
    checkOutput("t6_val_data", val_data0, 8'h45);
    checkOutput("t6_disabled_pulses", dis_pulse, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmc_dma_unit.md
Name: dmc_dma_unit

Overview:
- CPU-side responder for the APU's DMC sample-fetch interface.
- Latches the APU's DMC read request and stalls the 6502 core using NES DMC DMA timing: halt, dummy, optional alignment, then get.
- Takes the memory bus, reads the sample byte at {1'b1, dmc_addr}, and returns it to the APU on dmc_read_data with a one-cycle valid strobe.
- Sits between the APU, the CPU core's RDY input and the system bus mux.

Parameters:
- MEM_LAT, 1: CPU-enabled cycles from mem_re to mem_rdata being valid; legal values 1..2.
- PENDING_DEPTH, 1: requests held while busy; fixed at 1; any further request is dropped.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- cpu_clk_en  input  1  CPU cycle enable; all state advances only on cycles where this is high
- apu_put  input  1  1 = the current CPU cycle is a put (odd APU half), 0 = a get cycle
- dmc_re  input  1  APU fetch request, single-cycle pulse qualified by cpu_clk_en
- dmc_addr  input  15  APU sample address; sampled when dmc_re is accepted
- cpu_rw  input  1  CPU's current cycle type: 1 = read, 0 = write
- mem_rdata  input  8  system bus read data
- cpu_rdy  output  1  0 = halt the CPU core
- bus_grant  output  1  1 = the system bus mux selects this block's address
- mem_addr  output  16  bus address while bus_grant is high
- mem_re  output  1  bus read strobe
- dmc_read_data  output  8  fetched sample byte, held until the next fetch
- dmc_data_valid  output  1  one-cycle pulse, qualified by cpu_clk_en
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values: cpu_rdy=1, bus_grant=0, mem_addr=0, mem_re=0, dmc_read_data=0, dmc_data_valid=0, busy=0; FSM goes to IDLE and the pending slot is cleared.
- A reset asserted mid-transfer aborts the transfer immediately and releases cpu_rdy on the next clk.
- States and transitions (all taken only on cpu_clk_en):
  - IDLE: on dmc_re, latch addr_q = {1'b1, dmc_addr} and go to HALT; cpu_rdy drops to 0 in the same enabled cycle (registered, visible next clk).
  - HALT: the CPU may still be finishing a write, because the 6502 ignores RDY on writes. If cpu_rw=0, stay in HALT. If cpu_rw=1, go to DUMMY.
  - DUMMY: one stolen cycle, no bus access; go to ALIGN if apu_put=0, else go to GET.
  - ALIGN: one extra cycle so that the fetch lands on a get cycle; go to GET.
  - GET: bus_grant=1, mem_addr=addr_q, mem_re=1 for this one cycle, then go to WAIT.
  - WAIT: count MEM_LAT enabled cycles with bus_grant still high. On the last one, capture dmc_read_data=mem_rdata and pulse dmc_data_valid; go to HALT if a request is pending, else to IDLE with cpu_rdy=1.
- Stall length is 3 CPU cycles (halt, dummy, get) or 4 with the alignment cycle, plus any write-extended HALT cycles. This assumes MEM_LAT=1; each extra latency cycle adds one stall cycle.
- Pending slot:
  - dmc_re arriving in any non-IDLE state is latched into the one pending slot, address included.
  - A further dmc_re while the slot is full is dropped.
  - A dmc_re coincident with the WAIT-to-IDLE transition is treated as pending, so the FSM goes to HALT and cpu_rdy stays 0 with no gap.
- Back-to-back transfers skip the IDLE state but still re-run HALT.
- cpu_rdy stays 0 continuously from entering HALT until the transfer leaves WAIT.
- mem_addr holds its last value when bus_grant=0; bus consumers must ignore it then.
- Arithmetic: the address is pure concatenation. The $FFFF-to-$8000 wrap is the APU's responsibility; this block never increments addresses.
- Cycles with cpu_clk_en=0 freeze every register. dmc_data_valid is asserted only in the enabled cycle.

Decomposition:
- Shared apu package gets:
  - dma_state_e enum: IDLE, HALT, DUMMY, ALIGN, GET, WAIT.
  - DMC_ADDR_MSB constant 1'b1.
- Single module with no sub-modules: the FSM plus a 2-bit latency counter and the pending register are small enough to keep inline.

Test Plan:
- dmc_re with dmc_addr=15'h4000, apu_put=1 on DUMMY, cpu_rw=1, mem_rdata=8'hA5 -> mem_addr=16'hC000 in GET; cpu_rdy low for exactly 3 enabled cycles; dmc_read_data=8'hA5 with a single dmc_data_valid pulse.
- Same as the first case but apu_put=0 on DUMMY -> ALIGN is inserted; cpu_rdy low for 4 enabled cycles; fetch occurs on the get cycle.
- cpu_rw=0 for 2 cycles after dmc_re -> HALT is held for 2 extra cycles; total stall 5 cycles; mem_re asserted exactly once.
- Second dmc_re (addr 15'h0001) arrives during WAIT of the first, and a third arrives during the second's HALT -> two fetches at 16'h8000 and 16'h8001; third request dropped; cpu_rdy never rises between the two fetches.
- rst asserted in GET -> next clk: cpu_rdy=1, bus_grant=0, busy=0, no dmc_data_valid; a new dmc_re afterwards completes normally.
- cpu_clk_en toggling 1-in-12 with MEM_LAT=2 -> the state sequence is identical in enabled cycles; stall grows by 1; dmc_read_data matches mem_rdata sampled 2 enabled cycles after mem_re.
